// File: rtl/arm_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : arm_hazard_scoreboard
// Description : Hazard unit for the ARM pipeline. Records the destination of
//               every instruction in flight between the end of ID and
//               writeback, then drives the ID-stage stall and (in forwarding
//               mode) per-operand EXE forwarding selects. Also counts stall
//               cycles in a saturating counter.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst          clock / synchronous active-high reset
//   id_valid          ID holds a real instruction
//   id_src1, id_src2  source registers (src2 only read when id_two_src)
//   id_wb_en          ID instruction writes a register
//   id_mem_r_en       ID instruction is a load
//   id_dest           ID destination register
//   flush             squash the instruction currently in ID
//   hazard_stall      hold PC/IF/ID and insert a bubble
//   fwd_sel1/2        0 = register file, k = stage k (1 = EXE, youngest)
//   stall_count       saturating count of stall cycles
// ============================================================================
module arm_hazard_scoreboard #(
  parameter int STAGES = 3,
  parameter int REG_AW = 4,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16,
  parameter int SEL_W  = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_two_src,
  input  logic              id_wb_en,
  input  logic              id_mem_r_en,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              flush,
  output logic              hazard_stall,
  output logic [SEL_W-1:0]  fwd_sel1,
  output logic [SEL_W-1:0]  fwd_sel2,
  output logic [CNT_W-1:0]  stall_count
);

  // Entry k = stage k after ID (1 = EXE ... STAGES = WB)
  logic [STAGES:1]   valid_q, valid_d;
  logic [STAGES:1]   wb_q, wb_d;
  logic [STAGES:1]   mr_q, mr_d;
  logic [REG_AW-1:0] dest_q [1:STAGES];
  logic [REG_AW-1:0] dest_d [1:STAGES];
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [STAGES:1]   w_match1, w_match2;
  logic              w_stall;

  // Per-stage RAW match for each checked operand
  always_comb begin
    w_match1 = '0;
    w_match2 = '0;
    for (int k = 1; k <= STAGES; k++) begin
      w_match1[k] = id_valid & valid_q[k] & wb_q[k] & (dest_q[k] == id_src1);
      w_match2[k] = id_valid & id_two_src & valid_q[k] & wb_q[k] &
                    (dest_q[k] == id_src2);
    end
  end

  generate
    if (FWD_EN != 0) begin : g_fwd
      // Only a load still in EXE cannot be forwarded in time.
      always_comb begin
        w_stall  = mr_q[1] & (w_match1[1] | w_match2[1]);
        fwd_sel1 = '0;
        fwd_sel2 = '0;
        // Scan oldest to youngest so the youngest producer wins.
        for (int k = STAGES; k >= 1; k--) begin
          if (w_match1[k]) fwd_sel1 = SEL_W'(k);
          if (w_match2[k]) fwd_sel2 = SEL_W'(k);
        end
        if (w_stall) begin
          fwd_sel1 = '0;
          fwd_sel2 = '0;
        end
      end
    end else begin : g_nofwd
      assign w_stall  = (|w_match1) | (|w_match2);
      assign fwd_sel1 = '0;
      assign fwd_sel2 = '0;
    end
  endgenerate

  assign hazard_stall = w_stall;
  assign stall_count  = cnt_q;

  // Entries always advance; EXE takes the ID instruction or a bubble.
  always_comb begin
    valid_d[1] = id_valid & ~w_stall & ~flush;
    wb_d[1]    = id_wb_en;
    mr_d[1]    = id_mem_r_en;
    dest_d[1]  = id_dest;
    for (int k = 2; k <= STAGES; k++) begin
      valid_d[k] = valid_q[k-1];
      wb_d[k]    = wb_q[k-1];
      mr_d[k]    = mr_q[k-1];
      dest_d[k]  = dest_q[k-1];
    end
  end

  // A flushed cycle's stall never takes effect, so it is not counted.
  always_comb begin
    cnt_d = cnt_q;
    if (w_stall && !flush && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      wb_q    <= '0;
      mr_q    <= '0;
      cnt_q   <= '0;
      for (int k = 1; k <= STAGES; k++) dest_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      wb_q    <= wb_d;
      mr_q    <= mr_d;
      cnt_q   <= cnt_d;
      for (int k = 1; k <= STAGES; k++) dest_q[k] <= dest_d[k];
    end
  end

endmodule
`default_nettype wire

// File: doc/arm_hazard_scoreboard.md
# arm_hazard_scoreboard

Parametrised hazard unit for the ARM pipeline. It tracks the destination register of every instruction in flight between the end of ID and writeback, over a configurable number of stages. From that record it drives the ID-stage stall and, in forwarding mode, a per-operand forwarding select for EXE. It sits beside ID_Module and feeds the ID/EXE pipeline-register enables, and it also keeps a saturating stall counter for performance measurement.

## Interface
- STAGES, 3, in-flight stages tracked after ID (EXE, MEM, WB = 3); legal 2..8
- REG_AW, 4, register-address width
- FWD_EN, 1, 1 = forwarding mode (stall only on load-use), 0 = stall on any RAW match
- CNT_W, 16, stall-counter width
- SEL_W, $clog2(STAGES+1), forwarding-select width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_src1  in  REG_AW  first source register (Rn)
- id_src2  in  REG_AW  second source register (Rm / Rd for store)
- id_two_src  in  1  id_src2 is actually read
- id_wb_en  in  1  ID instruction writes a register
- id_mem_r_en  in  1  ID instruction is a load
- id_dest  in  REG_AW  ID destination register
- flush  in  1  branch taken in EXE; squash instruction currently in ID
- hazard_stall  out  1  hold PC/IF/ID and insert bubble
- fwd_sel1  out  SEL_W  source for operand 1: 0 = register file, k = stage k (1 = youngest/EXE)
- fwd_sel2  out  SEL_W  same for operand 2
- stall_count  out  CNT_W  saturating count of stall cycles

## Operation
- State: STAGES entries e[1..STAGES], each holding {valid, wb_en, mem_r, dest}. e[1] is EXE and e[STAGES] is WB.
- Match k for source s: e[k].valid & e[k].wb_en & e[k].dest == s.
- Operand 1 is checked whenever id_valid. Operand 2 is checked only when id_valid & id_two_src.
- FWD_EN=0: hazard_stall = any match, any k, on any checked operand. fwd_sel* held at 0.
- FWD_EN=1: hazard_stall = a checked operand matches e[1] and e[1].mem_r (load-use).
- FWD_EN=1, no stall: fwd_selN = smallest k that matches (youngest producer wins), 0 if none.
- FWD_EN=1, stall asserted: fwd_sel* = 0.
- Shift each edge: e[k] <= e[k-1] for k ≥ 2. Entries always advance; the scoreboard itself is never stalled.
- e[1] load: gets {id_valid, id_wb_en, id_mem_r_en, id_dest} when not hazard_stall and not flush. Otherwise e[1] gets a bubble (valid=0).
- flush and hazard_stall together: bubble; flush wins, and the stall is ignored for counting.
- e[STAGES] is the writeback stage. Forwarding from it is legal, so the register file need not be write-through.
- stall_count: +1 on each cycle where hazard_stall & ~flush. Saturates at all-ones with no wrap.

## Timing
- hazard_stall and fwd_sel* are combinational from the id_* inputs and registered entries, valid in the same cycle. There is no path from flush to hazard_stall.
- Issued instruction appears in e[1] one edge later and leaves e[STAGES] STAGES edges after issue.
- Load-use in FWD_EN=1 mode:
  - exactly one stall cycle;
  - the next cycle the load is in e[2] and fwd_sel = 2.
- FWD_EN=0: a dependent instruction stalls until the producer leaves e[STAGES]. That is at most STAGES cycles for a producer just issued.
- Reset, while rst high at an edge:
  - all entries valid=0 and stall_count=0;
  - hazard_stall=0 and fwd_sel*=0 in the following cycle;
  - reset mid-stall drops all pending hazards.
- Destination register 15 is tracked like any other register. No special case.

## Test plan
- FWD_EN=1, STAGES=3. ADD r1 issued, then SUB r2,r1,r3 next cycle:
  - hazard_stall=0 and fwd_sel1=1;
  - one cycle later on a third dependent, fwd_sel1=2.
- FWD_EN=1. LDR r4 then ADD r5,r4,r4 (two_src):
  - hazard_stall=1 for exactly one cycle;
  - after that fwd_sel1=fwd_sel2=2 and stall_count=1.
- FWD_EN=0, STAGES=3. ADD r1 then ORR r2,r1:
  - hazard_stall high 3 consecutive cycles, then 0;
  - stall_count=3.
- Two producers to r6 issued back-to-back, then a reader of r6: fwd_sel1=1, the younger producer.
- Load-use pattern with flush asserted in the same cycle:
  - hazard_stall may assert, but e[1] is a bubble and stall_count is unchanged;
  - the next instruction sees no match.
- CNT_W=2: 5 stall cycles give stall_count=3 (saturated). rst pulsed mid-stall gives stall_count=0, all fwd_sel=0 and hazard_stall=0 the following cycle.
